// File: rtl/alu_unit_pkg.sv
// Shared opcode encodings, field widths and datapath helpers for the ALU
// and its neighbours (decoder, reservation station).
package alu_unit_pkg;

    localparam int DEF_ROB_WIDTH     = 4;
    localparam int DEF_RS_TYPE_WIDTH = 5;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_SUB   = 5'd1,
        OP_SLL   = 5'd2,
        OP_SLT   = 5'd3,
        OP_SLTU  = 5'd4,
        OP_XOR   = 5'd5,
        OP_SRL   = 5'd6,
        OP_SRA   = 5'd7,
        OP_OR    = 5'd8,
        OP_AND   = 5'd9,
        OP_BEQ   = 5'd10,
        OP_BNE   = 5'd11,
        OP_BLT   = 5'd12,
        OP_BGE   = 5'd13,
        OP_BLTU  = 5'd14,
        OP_BGEU  = 5'd15,
        OP_ADDI  = 5'd16,
        OP_SUBI  = 5'd17,
        OP_SLLI  = 5'd18,
        OP_SLTI  = 5'd19,
        OP_SLTIU = 5'd20,
        OP_XORI  = 5'd21,
        OP_SRLI  = 5'd22,
        OP_SRAI  = 5'd23,
        OP_ORI   = 5'd24,
        OP_ANDI  = 5'd25,
        OP_LUI   = 5'd26,
        OP_AUIPC = 5'd27,
        OP_JALR  = 5'd28
    } alu_op_e;

    // fn is the low nibble of a register or immediate op (0..9)
    function automatic logic [31:0] alu_basic(input logic [3:0] fn,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (fn)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a << b[4:0];
            4'd3:    r = {31'd0, ($signed(a) < $signed(b))};
            4'd4:    r = {31'd0, (a < b)};
            4'd5:    r = a ^ b;
            4'd6:    r = a >> b[4:0];
            4'd7:    r = $signed(a) >>> b[4:0];
            4'd8:    r = a | b;
            4'd9:    r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic branch_taken(input logic [4:0] code,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic t;
        t = 1'b0;
        case (code)
            OP_BEQ:  t = (a == b);
            OP_BNE:  t = (a != b);
            OP_BLT:  t = ($signed(a) < $signed(b));
            OP_BGE:  t = ($signed(a) >= $signed(b));
            OP_BLTU: t = (a < b);
            OP_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational ALU datapath: decodes the op code and produces the result
// and the jump-target flag. Registered by alu_unit.
module alu_compute
    import alu_unit_pkg::*;
#(
    parameter int RS_TYPE_WIDTH = DEF_RS_TYPE_WIDTH
) (
    input  logic [RS_TYPE_WIDTH-1:0] alu_type,
    input  logic [31:0]              data_j,
    input  logic [31:0]              data_k,
    input  logic [31:0]              imm,
    output logic [31:0]              result,
    output logic                     set_jump_addr
);

    logic [4:0] code;
    logic       code_oob;

    assign code     = alu_type[4:0];
    // codes wider than the 5-bit space are undefined
    assign code_oob = |(alu_type >> 5);

    always_comb begin
        result        = 32'd0;
        set_jump_addr = 1'b0;
        if (!code_oob) begin
            if (code <= OP_AND) begin
                result = alu_basic(code[3:0], data_j, data_k);
            end else if (code <= OP_BGEU) begin
                result = {31'd0, branch_taken(code, data_j, data_k)};
            end else if (code <= OP_ANDI) begin
                result = alu_basic(code[3:0], data_j, imm);
            end else begin
                case (code)
                    OP_LUI:   result = imm;
                    OP_AUIPC: result = data_k + imm;
                    OP_JALR: begin
                        result        = (data_j + imm) & ~32'd1;
                        set_jump_addr = 1'b1;
                    end
                    default:  result = 32'd0;
                endcase
            end
        end
    end

endmodule

// File: rtl/alu_unit.sv
// Single-cycle ALU execution unit: accepts one op per cycle from the
// reservation station and presents a registered result with its ROB tag.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int ROB_WIDTH     = DEF_ROB_WIDTH,
    parameter int RS_TYPE_WIDTH = DEF_RS_TYPE_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     alu_en,
    input  logic [ROB_WIDTH-1:0]     alu_rob_id,
    input  logic [31:0]              alu_data_j,
    input  logic [31:0]              alu_data_k,
    input  logic [31:0]              alu_imm,
    input  logic [RS_TYPE_WIDTH-1:0] alu_type,
    output logic                     alu_rdy,
    output logic [ROB_WIDTH-1:0]     alu_rob_id_out,
    output logic [31:0]              alu_result,
    output logic                     alu_set_jump_addr
);

    logic [31:0] comb_result;
    logic        comb_jump;

    alu_compute #(
        .RS_TYPE_WIDTH (RS_TYPE_WIDTH)
    ) u_compute (
        .alu_type      (alu_type),
        .data_j        (alu_data_j),
        .data_k        (alu_data_k),
        .imm           (alu_imm),
        .result        (comb_result),
        .set_jump_addr (comb_jump)
    );

    // Without an accept only alu_rdy drops; the payload is left as-is.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            alu_rdy           <= 1'b0;
            alu_rob_id_out    <= '0;
            alu_result        <= 32'd0;
            alu_set_jump_addr <= 1'b0;
        end else if (rdy_in) begin
            if (flush) begin
                alu_rdy           <= 1'b0;
                alu_rob_id_out    <= '0;
                alu_result        <= 32'd0;
                alu_set_jump_addr <= 1'b0;
            end else if (alu_en) begin
                alu_rdy           <= 1'b1;
                alu_rob_id_out    <= alu_rob_id;
                alu_result        <= comb_result;
                alu_set_jump_addr <= comb_jump;
            end else begin
                alu_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with an expected-result queue.
module tb_alu_unit;
    import alu_unit_pkg::*;

    localparam int RW = DEF_ROB_WIDTH;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          flush;
    logic          alu_en;
    logic [RW-1:0] alu_rob_id;
    logic [31:0]   alu_data_j;
    logic [31:0]   alu_data_k;
    logic [31:0]   alu_imm;
    logic [4:0]    alu_type;
    logic          alu_rdy;
    logic [RW-1:0] alu_rob_id_out;
    logic [31:0]   alu_result;
    logic          alu_set_jump_addr;

    alu_unit dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .flush             (flush),
        .alu_en            (alu_en),
        .alu_rob_id        (alu_rob_id),
        .alu_data_j        (alu_data_j),
        .alu_data_k        (alu_data_k),
        .alu_imm           (alu_imm),
        .alu_type          (alu_type),
        .alu_rdy           (alu_rdy),
        .alu_rob_id_out    (alu_rob_id_out),
        .alu_result        (alu_result),
        .alu_set_jump_addr (alu_set_jump_addr)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [RW-1:0] tag;
        logic [31:0]   res;
        logic          jmp;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] j,
                                          input logic [31:0] k, input logic [31:0] imm);
        logic [31:0] b;
        logic [4:0]  sh;
        b  = c[4] ? imm : k;
        sh = b[4:0];
        case (c)
            5'd0,  5'd16: return j + b;
            5'd1,  5'd17: return j - b;
            5'd2,  5'd18: return j << sh;
            5'd3,  5'd19: return ($signed(j) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4,  5'd20: return (j < b) ? 32'd1 : 32'd0;
            5'd5,  5'd21: return j ^ b;
            5'd6,  5'd22: return j >> sh;
            5'd7,  5'd23: return $signed(j) >>> sh;
            5'd8,  5'd24: return j | b;
            5'd9,  5'd25: return j & b;
            5'd10: return (j == k) ? 32'd1 : 32'd0;
            5'd11: return (j != k) ? 32'd1 : 32'd0;
            5'd12: return ($signed(j) < $signed(k)) ? 32'd1 : 32'd0;
            5'd13: return ($signed(j) >= $signed(k)) ? 32'd1 : 32'd0;
            5'd14: return (j < k) ? 32'd1 : 32'd0;
            5'd15: return (j >= k) ? 32'd1 : 32'd0;
            5'd26: return imm;
            5'd27: return k + imm;
            5'd28: return (j + imm) & 32'hFFFF_FFFE;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".rdy"}, {31'd0, alu_rdy}, 32'd0);
        chk({tag, ".tag"}, 32'(alu_rob_id_out), 32'd0);
        chk({tag, ".res"}, alu_result, 32'd0);
        chk({tag, ".jmp"}, {31'd0, alu_set_jump_addr}, 32'd0);
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk_in);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ".rdy"}, {31'd0, alu_rdy}, 32'd1);
            chk({tag, ".tag"}, 32'(alu_rob_id_out), 32'(e.tag));
            chk({tag, ".res"}, alu_result, e.res);
            chk({tag, ".jmp"}, {31'd0, alu_set_jump_addr}, {31'd0, e.jmp});
            last_exp = e;
        end else begin
            chk({tag, ".rdy_idle"}, {31'd0, alu_rdy}, 32'd0);
        end
    endtask

    task automatic drive(input logic [4:0] c, input logic [31:0] j, input logic [31:0] k,
                         input logic [31:0] imm, input logic [RW-1:0] tag);
        alu_en     = 1'b1;
        flush      = 1'b0;
        alu_type   = c;
        alu_data_j = j;
        alu_data_k = k;
        alu_imm    = imm;
        alu_rob_id = tag;
    endtask

    task automatic issue(input string name, input logic [4:0] c, input logic [31:0] j,
                         input logic [31:0] k, input logic [31:0] imm, input logic [RW-1:0] tag,
                         input logic [31:0] exp_res, input logic exp_jmp);
        exp_t e;
        drive(c, j, k, imm, tag);
        e.tag = tag;
        e.res = exp_res;
        e.jmp = exp_jmp;
        exp_q.push_back(e);
        tick_check(name);
    endtask

    task automatic idle(input string name);
        alu_en = 1'b0;
        flush  = 1'b0;
        tick_check(name);
    endtask

    initial begin
        logic [31:0] lj, lk, li;
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; alu_en = 1'b0;
        alu_rob_id = '0; alu_data_j = '0; alu_data_k = '0; alu_imm = '0; alu_type = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_zero("reset");
        rst_in = 1'b0;
        idle("post_reset");

        issue("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 4'd3, 32'h8000_0000, 1'b0);
        idle("add_ovf_drop");

        issue("srai", 5'd23, 32'h8000_0000, 32'd0, 32'h24, 4'd1, 32'hF800_0000, 1'b0);
        issue("sltu", 5'd4, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd2, 32'd1, 1'b0);
        issue("blt", 5'd12, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd4, 32'd1, 1'b0);
        issue("bltu", 5'd14, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd5, 32'd0, 1'b0);
        issue("jalr", 5'd28, 32'h1001, 32'd0, 32'd4, 4'd6, 32'h1004, 1'b1);
        issue("lui", 5'd26, 32'h1234, 32'h5678, 32'hABCD_E000, 4'd7, 32'hABCD_E000, 1'b0);
        issue("auipc", 5'd27, 32'h1234, 32'h0000_4000, 32'h0001_0000, 4'd8, 32'h0001_4000, 1'b0);
        issue("undef", 5'd30, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 32'd0, 1'b0);
        issue("bge", 5'd13, 32'd0, 32'hFFFF_FFFF, 32'd0, 4'd10, 32'd1, 1'b0);
        issue("beq", 5'd10, 32'h55, 32'h55, 32'd0, 4'd11, 32'd1, 1'b0);
        idle("branch_drop");

        // register and immediate ops, back-to-back against the model
        lj = 32'h8000_00F3; lk = 32'h0000_0025; li = 32'hFFFF_FF81;
        for (int i = 0; i < 20; i++) begin
            logic [4:0] c;
            c = (i < 10) ? 5'(i) : 5'(i + 6);
            issue($sformatf("op%0d", c), c, lj, lk, li, 4'(i), model(c, lj, lk, li), 1'b0);
        end
        idle("ops_drop");

        // dispatch alongside flush is dropped and outputs clear
        issue("pre_flush", 5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 4'd12, 32'hFF00_FF00, 1'b0);
        drive(5'd0, 32'd1, 32'd1, 32'd0, 4'd13);
        flush = 1'b1;
        @(posedge clk_in);
        #1;
        chk_zero("flush");
        idle("post_flush");

        // rdy_in low freezes a pending result even with new dispatch presented
        issue("pre_hold", 5'd8, 32'h0000_00F0, 32'h0000_000F, 32'd0, 4'd14, 32'h0000_00FF, 1'b0);
        drive(5'd0, 32'd7, 32'd7, 32'd0, 4'd15);
        rdy_in = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (n == 1) flush = 1'b1;
            @(posedge clk_in);
            #1;
            chk($sformatf("hold%0d.rdy", n), {31'd0, alu_rdy}, 32'd1);
            chk($sformatf("hold%0d.tag", n), 32'(alu_rob_id_out), 32'(last_exp.tag));
            chk($sformatf("hold%0d.res", n), alu_result, last_exp.res);
            chk($sformatf("hold%0d.jmp", n), {31'd0, alu_set_jump_addr}, {31'd0, last_exp.jmp});
        end
        rdy_in = 1'b1;
        idle("post_hold");

        for (int t = 0; t < 4; t++)
            issue($sformatf("b2b%0d", t), 5'd16, 32'(100 * t), 32'd0, 32'd1, 4'(t),
                  32'(100 * t + 1), 1'b0);

        // reset asserted mid-cycle with an op being dispatched
        drive(5'd0, 32'd2, 32'd3, 32'd0, 4'd9);
        #3;
        rst_in = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge clk_in);
        #1;
        chk_zero("rst_hold");
        rst_in = 1'b0;
        alu_en = 1'b0;
        exp_q.delete();
        idle("post_rst");
        issue("after_rst", 5'd1, 32'd10, 32'd3, 32'd0, 4'd2, 32'd7, 1'b0);
        idle("final_drop");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port rdy_in, input, 1 bit: global enable; when low, the block captures nothing and holds all state.
REQ-004 SHALL have port flush, input, 1 bit: pipeline flush, qualified by rdy_in.
REQ-005 SHALL have port alu_en, input, 1 bit: dispatch valid from the reservation station.
REQ-006 SHALL have port alu_rob_id, input, `ROB_WIDTH bits: ROB tag of the dispatched op.
REQ-007 SHALL have ports alu_data_j, alu_data_k and alu_imm, input, 32 bits each: operand j (rs1), operand k (rs2, or PC for AUIPC), and the immediate.
REQ-008 SHALL have port alu_type, input, `RS_TYPE_WIDTH (5) bits: operation code.
REQ-009 SHALL have port alu_rdy, output, 1 bit: result valid, exactly one cycle per accepted op.
REQ-010 SHALL have port alu_rob_id_out, output, `ROB_WIDTH bits: tag of the result.
REQ-011 SHALL have port alu_result, output, 32 bits: result value.
REQ-012 SHALL have port alu_set_jump_addr, output, 1 bit: alu_result is a jump target for the ROB.
REQ-013 SHALL have parameters `ROB_WIDTH and `RS_TYPE_WIDTH, both defaulting from params.v, sizing the tag and opcode fields.

Function
REQ-014 SHALL always accept dispatch; there is no backpressure port, and an op is accepted at any edge where rdy_in && alu_en && !flush.
REQ-015 SHALL register all outputs: a result appears exactly 1 cycle after acceptance, and alu_rdy stays high for that one cycle only.
REQ-016 SHALL deassert alu_rdy at the next edge after any edge with no accepted op.
REQ-017 SHALL, on an edge with rdy_in && flush, clear alu_rdy, alu_result, alu_rob_id_out and alu_set_jump_addr to 0 and drop any simultaneous dispatch.
REQ-018 SHALL hold all outputs unchanged while rdy_in is low; a pending alu_rdy remains asserted.
REQ-019 SHALL decode codes 0-9 with second operand alu_data_k, in order: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
REQ-020 SHALL decode codes 16-25 (bit 4 set) as the same ten ops with second operand alu_imm; SUB-imm (17) is defined but not issued.
REQ-021 SHALL use only the low 5 bits of the second operand as the shift amount; SRA sign-extends; SLT is signed and SLTU unsigned; all arithmetic wraps modulo 2^32.
REQ-022 SHALL decode codes 10-15 as BEQ, BNE, BLT, BGE, BLTU, BGEU comparing j against k, with alu_result = {31'b0, taken} and alu_set_jump_addr = 0.
REQ-023 SHALL decode code 26 as LUI: alu_result = alu_imm.
REQ-024 SHALL decode code 27 as AUIPC: alu_result = alu_data_k + alu_imm.
REQ-025 SHALL decode code 28 as JALR: alu_result = (alu_data_j + alu_imm) & ~1 and alu_set_jump_addr = 1.
REQ-026 SHALL set alu_set_jump_addr = 0 for every op other than JALR.
REQ-027 SHALL treat undefined codes as producing alu_result = 0 with alu_set_jump_addr = 0; alu_rdy still asserts.
REQ-028 SHALL allow back-to-back accepts on consecutive cycles, giving one result per cycle with tags in dispatch order.

Reset
REQ-029 SHALL, while rst_in is high and independent of the clock, force alu_rdy = 0, alu_rob_id_out = 0, alu_result = 0 and alu_set_jump_addr = 0.
REQ-030 SHALL discard an op accepted in the cycle during which reset asserts; no result is produced after reset deasserts.

Structure
REQ-031 SHALL take all opcode constants and `RS_TYPE_WIDTH/`ROB_WIDTH from params.v, shared with the decoder and the reservation station.
REQ-032 SHALL contain one combinational sub-module, alu_compute (type, j, k, imm -> result, set_jump_addr), registered by alu_unit.

Verification
REQ-033 SHALL cover: ADD j=0x7FFFFFFF k=1 tag 3 -> next cycle alu_rdy=1, result 0x80000000, tag 3, and alu_rdy=0 the cycle after.
REQ-034 SHALL cover: SRA-imm j=0x80000000 imm=0x24 -> result 0xF8000000 (shift amount 4); SLTU j=1 k=0xFFFFFFFF -> result 1.
REQ-035 SHALL cover: BLT j=0xFFFFFFFF k=0 -> result 1 with set_jump_addr=0; BLTU with the same operands -> result 0.
REQ-036 SHALL cover: JALR j=0x1001 imm=4 -> result 0x1004 with set_jump_addr=1.
REQ-037 SHALL cover: dispatch with flush=1 -> alu_rdy=0 next cycle; rdy_in=0 for 3 cycles after a result -> outputs held unchanged.
REQ-038 SHALL cover: 4 back-to-back dispatches with tags 0..3 -> 4 consecutive alu_rdy cycles with tags 0..3; rst_in pulsed mid-stream -> outputs immediately 0.
